prog_counter: RTL and testbench

Parametrised, programmable successor to the fixed free-running counter in the workshop blocks.
- Counts up or down by a compile-time step toward a programmable limit, in one-shot or wrap mode.
- Supports start/stop/load control, a sticky completion flag and a terminal-count pulse.
- Intended as the reusable timer/sequencer primitive for later workshop datapaths.

---
 rtl/prog_counter.sv | 162 ++++++++++++++++
 tb/tb_prog_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Programmable up/down counter with one-shot/wrap modes, sticky completion flag and terminal pulse.
// Optional prescaler enabled by defining PROG_COUNTER_PRESCALE_EN (adds parameter PRESCALE).
module prog_counter #(
  parameter int DWIDTH = 8,
  parameter int STEP   = 1
`ifdef PROG_COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic [DWIDTH-1:0] load_val,
  input  logic [DWIDTH-1:0] limit,
  input  logic              dir,
  input  logic              mode,
  output logic [DWIDTH-1:0] count,
  output logic              busy,
  output logic              complete,
  output logic              tc_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DWIDTH:0]   STEP_W = (DWIDTH+1)'(STEP);
  localparam logic [DWIDTH-1:0] STEP_D = DWIDTH'(STEP);

  state_t            state, state_n;
  logic [DWIDTH-1:0] count_n, base, base_n, lim_q, lim_n;
  logic              dir_q, dir_n, mode_q, mode_n;
  logic              complete_n, tc_n;
  // Set after a wrap-mode terminal tick: the following tick reloads base.
  logic              reload_pend, reload_n;
  logic              tick_en;

`ifdef PROG_COUNTER_PRESCALE_EN
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PSW-1:0] psc, psc_n;
  assign tick_en = (psc == PSW'(PRESCALE - 1));
`else
  assign tick_en = 1'b1;
`endif

  // Comparisons are one bit wider than the counter so no sum or limit+step can wrap.
  logic [DWIDTH:0] sum_w, limstep_w;
  logic            terminal;

  assign sum_w      = {1'b0, count} + STEP_W;
  assign limstep_w  = {1'b0, lim_q} + STEP_W;
  assign terminal   = dir_q ? ({1'b0, count} <= limstep_w) : (sum_w >= {1'b0, lim_q});
  assign busy       = (state == RUN);

  always_comb begin
    state_n    = state;
    count_n    = count;
    base_n     = base;
    lim_n      = lim_q;
    dir_n      = dir_q;
    mode_n     = mode_q;
    complete_n = complete;
    tc_n       = 1'b0;
    reload_n   = reload_pend;
`ifdef PROG_COUNTER_PRESCALE_EN
    psc_n      = psc;
`endif
    if (load) begin
      count_n    = load_val;
      base_n     = load_val;
      state_n    = IDLE;
      complete_n = 1'b0;
      reload_n   = 1'b0;
`ifdef PROG_COUNTER_PRESCALE_EN
      psc_n      = '0;
`endif
    end else if (stop && state == RUN) begin
      state_n  = IDLE;
      reload_n = 1'b0;
`ifdef PROG_COUNTER_PRESCALE_EN
      psc_n    = '0;
`endif
    end else if (start && state != RUN) begin
      lim_n    = limit;
      dir_n    = dir;
      mode_n   = mode;
      state_n  = RUN;
      reload_n = 1'b0;
      if (state == DONE) begin
        count_n    = base;
        complete_n = 1'b0;
      end
`ifdef PROG_COUNTER_PRESCALE_EN
      psc_n    = '0;
`endif
    end else if (state == RUN) begin
      if (tick_en) begin
`ifdef PROG_COUNTER_PRESCALE_EN
        psc_n = '0;
`endif
        if (reload_pend) begin
          count_n  = base;
          reload_n = 1'b0;
        end else if (terminal) begin
          count_n = lim_q;
          tc_n    = 1'b1;
          if (mode_q) begin
            reload_n = 1'b1;
          end else begin
            state_n    = DONE;
            complete_n = 1'b1;
          end
        end else if (dir_q) begin
          count_n = count - STEP_D;
        end else begin
          count_n = sum_w[DWIDTH-1:0];
        end
      end
`ifdef PROG_COUNTER_PRESCALE_EN
      else begin
        psc_n = psc + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      base        <= '0;
      lim_q       <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 1'b0;
      complete    <= 1'b0;
      tc_pulse    <= 1'b0;
      reload_pend <= 1'b0;
`ifdef PROG_COUNTER_PRESCALE_EN
      psc         <= '0;
`endif
    end else begin
      state       <= state_n;
      count       <= count_n;
      base        <= base_n;
      lim_q       <= lim_n;
      dir_q       <= dir_n;
      mode_q      <= mode_n;
      complete    <= complete_n;
      tc_pulse    <= tc_n;
      reload_pend <= reload_n;
`ifdef PROG_COUNTER_PRESCALE_EN
      psc         <= psc_n;
`endif
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: two instances (STEP=1 and STEP=3) driven in parallel and
// checked against an integer reference model plus directed expectations.
module tb_prog_counter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic start, stop, load, dir, mode;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count0, count1;
  logic busy0, busy1, complete0, complete1, tc0, tc1;
  logic [W+2:0] obs0, obs1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  prog_counter #(.DWIDTH(W), .STEP(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .dir(dir), .mode(mode),
    .count(count0), .busy(busy0), .complete(complete0), .tc_pulse(tc0)
  );

  prog_counter #(.DWIDTH(W), .STEP(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .dir(dir), .mode(mode),
    .count(count1), .busy(busy1), .complete(complete1), .tc_pulse(tc1)
  );

  assign obs0 = {count0, busy0, complete0, tc0};
  assign obs1 = {count1, busy1, complete1, tc1};

  // st: 0 idle, 1 running, 2 finished
  typedef struct {
    int count; int base; int lim; int dir; int mode;
    int st; int comp; int tc; int pend;
  } model_t;

  model_t m0, m1;

  function automatic model_t mreset();
    model_t m;
    m.count = 0; m.base = 0; m.lim = 0; m.dir = 0; m.mode = 0;
    m.st = 0; m.comp = 0; m.tc = 0; m.pend = 0;
    return m;
  endfunction

  // One clock edge of the counter's rules, in plain integer arithmetic.
  function automatic model_t mstep(input model_t m, input int st);
    model_t n = m;
    int nxt;
    bit reached;
    n.tc = 0;
    if (load) begin
      n.count = int'(load_val); n.base = int'(load_val);
      n.st = 0; n.comp = 0; n.pend = 0;
    end else if (stop && m.st == 1) begin
      n.st = 0; n.pend = 0;
    end else if (start && m.st != 1) begin
      n.lim = int'(limit); n.dir = int'(dir); n.mode = int'(mode);
      if (m.st == 2) begin
        n.count = m.base; n.comp = 0;
      end
      n.st = 1; n.pend = 0;
    end else if (m.st == 1) begin
      if (m.pend != 0) begin
        n.count = m.base; n.pend = 0;
      end else begin
        nxt = (m.dir != 0) ? m.count - st : m.count + st;
        reached = (m.dir != 0) ? (nxt <= m.lim) : (nxt >= m.lim);
        if (reached) begin
          n.count = m.lim; n.tc = 1;
          if (m.mode != 0) n.pend = 1;
          else begin n.st = 2; n.comp = 1; end
        end else begin
          n.count = nxt;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [W+2:0] mexp(input model_t m);
    return {W'(m.count), (m.st == 1), (m.comp != 0), (m.tc != 0)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    m0 = mstep(m0, 1);
    m1 = mstep(m1, 3);
    #1;
  endtask

  task automatic drive_idle();
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [W-1:0] lim, input logic d, input logic md);
    limit = lim; dir = d; mode = md; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared += 2;
    if (obs0 !== '0) begin mismatched++; $display("FAIL reset_s1 got=%h want=0", obs0); end
    if (obs1 !== '0) begin mismatched++; $display("FAIL reset_s3 got=%h want=0", obs1); end
    reset = 1'b0;
    cycle();
    compared += 2;
    if (obs0 !== mexp(m0)) begin mismatched++; $display("FAIL reset_idle_s1 got=%h want=%h", obs0, mexp(m0)); end
    if (obs1 !== mexp(m1)) begin mismatched++; $display("FAIL reset_idle_s3 got=%h want=%h", obs1, mexp(m1)); end
  endtask

  task automatic test_up_oneshot();
    do_load(8'd0);
    do_start(8'd5, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      compared += 3;
      if (count0 !== W'(i > 5 ? 5 : i)) begin
        mismatched++; $display("FAIL up_count step=%0d got=%0d want=%0d", i, count0, (i > 5 ? 5 : i));
      end
      if ({busy0, complete0, tc0} !== {(i < 5), (i >= 5), (i == 5)}) begin
        mismatched++; $display("FAIL up_flags step=%0d got=%b want=%b", i, {busy0, complete0, tc0}, {(i < 5), (i >= 5), (i == 5)});
      end
      if (obs1 !== mexp(m1)) begin mismatched++; $display("FAIL up_model_s3 step=%0d got=%h want=%h", i, obs1, mexp(m1)); end
    end
  endtask

  task automatic test_step3();
    int seq[4] = '{3, 6, 9, 10};
    do_load(8'd0);
    do_start(8'd10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      compared += 2;
      if (count1 !== W'(seq[i])) begin mismatched++; $display("FAIL step3_count i=%0d got=%0d want=%0d", i, count1, seq[i]); end
      if (obs0 !== mexp(m0)) begin mismatched++; $display("FAIL step3_model_s1 i=%0d got=%h want=%h", i, obs0, mexp(m0)); end
    end
    compared++;
    if (complete1 !== 1'b1 || busy1 !== 1'b0) begin
      mismatched++; $display("FAIL step3_done got=%b%b want=10", complete1, busy1);
    end
    do_start(8'd10, 1'b0, 1'b0);
    compared++;
    if (count1 !== 8'd0 || complete1 !== 1'b0 || busy1 !== 1'b1) begin
      mismatched++; $display("FAIL step3_restart got=%0d/%b/%b want=0/0/1", count1, complete1, busy1);
    end
    cycle();
    compared++;
    if (count1 !== 8'd3) begin mismatched++; $display("FAIL step3_repeat got=%0d want=3", count1); end
  endtask

  task automatic test_down_wrap();
    int seq[7] = '{9, 8, 7, 10, 9, 8, 7};
    do_load(8'd10);
    do_start(8'd7, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle();
      compared += 3;
      if (count0 !== W'(seq[i])) begin mismatched++; $display("FAIL wrap_count i=%0d got=%0d want=%0d", i, count0, seq[i]); end
      if ({tc0, complete0, busy0} !== {(seq[i] == 7), 1'b0, 1'b1}) begin
        mismatched++; $display("FAIL wrap_flags i=%0d got=%b want=%b", i, {tc0, complete0, busy0}, {(seq[i] == 7), 1'b0, 1'b1});
      end
      if (obs1 !== mexp(m1)) begin mismatched++; $display("FAIL wrap_model_s3 i=%0d got=%h want=%h", i, obs1, mexp(m1)); end
    end
  endtask

  task automatic test_stop_resume();
    bit hit = 0;
    do_load(8'd0);
    do_start(8'd20, 1'b0, 1'b0);
    for (int i = 0; i < 30 && !hit; i++) begin
      cycle();
      hit = (m0.count == 4);
    end
    compared++;
    if (!hit || count0 !== 8'd4) begin mismatched++; $display("FAIL stop_reach got=%0d want=4", count0); end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (count0 !== 8'd4 || busy0 !== 1'b0) begin
        mismatched++; $display("FAIL stop_hold i=%0d got=%0d/%b want=4/0", i, count0, busy0);
      end
      if (i < 2) cycle();
    end
    do_start(8'd20, 1'b0, 1'b0);
    for (int i = 5; i <= 6; i++) begin
      cycle();
      compared++;
      if (count0 !== W'(i)) begin mismatched++; $display("FAIL stop_resume got=%0d want=%0d", count0, i); end
    end
    load = 1'b1; stop = 1'b1; start = 1'b1; load_val = 8'd9;
    cycle();
    drive_idle();
    compared += 2;
    if (count0 !== 8'd9 || busy0 !== 1'b0) begin mismatched++; $display("FAIL load_prio got=%0d/%b want=9/0", count0, busy0); end
    if (obs1 !== mexp(m1)) begin mismatched++; $display("FAIL load_prio_s3 got=%h want=%h", obs1, mexp(m1)); end
    cycle();
    compared++;
    if (count0 !== 8'd9) begin mismatched++; $display("FAIL load_idle got=%0d want=9", count0); end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    do_load(8'd0);
    do_start(8'd50, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      hit = (m0.count == 6);
    end
    compared++;
    if (!hit || count0 !== 8'd6) begin mismatched++; $display("FAIL areset_reach got=%0d want=6", count0); end
    #2 reset = 1'b1;
    #1;
    m0 = mreset();
    m1 = mreset();
    compared += 2;
    if (obs0 !== '0) begin mismatched++; $display("FAIL areset_s1 got=%h want=0", obs0); end
    if (obs1 !== '0) begin mismatched++; $display("FAIL areset_s3 got=%h want=0", obs1); end
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      compared++;
      if (obs0 !== '0 || obs1 !== '0) begin
        mismatched++; $display("FAIL areset_quiet i=%0d got=%h/%h want=0", i, obs0, obs1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 5) == 0);
      dir   = 1'(($urandom_range(0, 1)));
      mode  = 1'(($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) begin
        load_val = W'($urandom_range(0, 12));
        limit    = W'($urandom_range(0, 12));
      end else begin
        load_val = W'($urandom_range(0, 255));
        limit    = W'($urandom_range(0, 255));
      end
      cycle();
      compared += 2;
      if (obs0 !== mexp(m0)) begin mismatched++; $display("FAIL rand_s1 cyc=%0d got=%h want=%h", i, obs0, mexp(m0)); end
      if (obs1 !== mexp(m1)) begin mismatched++; $display("FAIL rand_s3 cyc=%0d got=%h want=%h", i, obs1, mexp(m1)); end
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    load_val = '0; limit = '0; dir = 1'b0; mode = 1'b0;
    m0 = mreset();
    m1 = mreset();
    test_reset();
    test_up_oneshot();
    test_step3();
    test_down_wrap();
    test_stop_resume();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
